dds_controller: RTL and testbench
=================================

Name: dds_controller

Overview:
- Parameter and display sequencer for the DDS generator.
- Takes single-cycle step pulses from the frequency and amplitude encoder decoders and keeps saturating tuning-word and amplitude registers.
- Commits new tuning words phase-coherently at phase-accumulator wrap.
- Schedules the shared binary-to-BCD converter between frequency and amplitude readouts, with a timed amplitude-display hold.

Parameters:
- TW_WIDTH, 16: tuning word width.
- TW_RESET, 1: tuning word after reset.
- TW_MAX, 65535: upper saturation limit of tuning word (lower limit 0).
- AMPL_WIDTH, 8: amplitude width.
- AMPL_RESET, 255: amplitude after reset (full scale).
- HOLD_CYCLES, 50_000_000: cycles the amplitude readout stays on display before reverting to frequency.

Ports:
- Clock  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- FreqInc_i  in  1  one-cycle pulse, tuning word +1.
- FreqDec_i  in  1  one-cycle pulse, tuning word -1.
- AmplInc_i  in  1  one-cycle pulse, amplitude +1.
- AmplDec_i  in  1  one-cycle pulse, amplitude -1.
- PhaseWrap_i  in  1  one-cycle pulse on phase-accumulator overflow.
- TuningWord_o  out  TW_WIDTH  committed tuning word to the accumulator.
- Amplitude_o  out  AMPL_WIDTH  amplitude scale to the output multiplier.
- ConvStart_o  out  1  one-cycle start to the BCD converter.
- ConvValue_o  out  TW_WIDTH  value to convert; amplitude is zero-extended.
- ConvDone_i  in  1  one-cycle pulse, converter result valid.
- DisplaySel_o  out  1  0 = display shows frequency, 1 = display shows amplitude.

Behaviour:
- Reset (async, active-high):
  - TwPending = TuningWord_o = TW_RESET; Amplitude_o = AMPL_RESET.
  - FSM = IDLE; ConvStart_o = 0; ConvValue_o = 0; DisplaySel_o = 0.
  - FreqDirty = 1 (forces an initial readout); AmplDirty = 0; LastSel = 1; hold timer cleared and inactive.
- Frequency steps:
  - Inc updates TwPending (saturating at TW_MAX); Dec updates TwPending (saturating at 0).
  - Inc and Dec in the same cycle: no change.
- Tuning-word commit:
  - TuningWord_o <= TwPending on PhaseWrap_i.
  - Also commits on any cycle where TuningWord_o == 0, so the accumulator cannot deadlock.
  - Step and wrap in the same cycle: the commit uses the pre-step TwPending; the step is applied at the next wrap.
  - Any commit that changes TuningWord_o sets FreqDirty.
- Amplitude steps:
  - Amplitude_o updates one cycle after the pulse, saturating at 0 and 2^AMPL_WIDTH-1.
  - Inc and Dec together: no change.
  - A change sets AmplDirty. A saturated step changes nothing and sets no flag.
- Display FSM (IDLE, START, WAIT):
  - IDLE: if any dirty flag is set, choose a source, capture ConvValue_o, clear that source's flag and go to START.
    - Both flags set: choose the source opposite LastSel (alternating).
  - START: ConvStart_o = 1 for exactly this cycle; go to WAIT.
  - WAIT: on ConvDone_i, DisplaySel_o <= chosen source, LastSel <= chosen source, go to IDLE.
  - ConvDone_i outside WAIT is ignored.
  - A change during START/WAIT re-sets its flag and causes a fresh conversion afterwards. The in-flight value is not modified.
- Latency:
  - Amplitude pulse at cycle n gives Amplitude_o at n+1.
  - From IDLE, ConvStart_o asserts at n+3.
- Hold timer:
  - Loaded with HOLD_CYCLES on ConvDone_i for an amplitude conversion, counting down each cycle.
  - On reaching 0, it sets FreqDirty so the display reverts to frequency.
  - Reloaded by each further amplitude conversion.
  - Cancelled by a frequency conversion completing.
- Reset mid-conversion: FSM returns to IDLE and the pending converter result is ignored. After reset, FreqDirty triggers a new conversion.

Decomposition:
- Shared package dds_pkg holds:
  - FSM state encodings (IDLE/START/WAIT).
  - DISP_FREQ = 0, DISP_AMPL = 1.
  - Default TW_WIDTH/AMPL_WIDTH constants.
- One natural sub-module, saturating_counter:
  - Parameterised width, reset value and max.
  - Inc/Dec inputs; Changed_o pulse output.
  - Instantiated for TwPending and Amplitude_o.

Test Plan:
- Reset, then no activity → TuningWord_o = 1 and Amplitude_o = 255; one ConvStart_o with ConvValue_o = 1; after ConvDone_i, DisplaySel_o = 0.
- 15 FreqInc pulses, PhaseWrap_i every 20 cycles → TuningWord_o steps only on wraps and reaches 16; FreqInc coincident with PhaseWrap_i is committed at the following wrap.
- 255 AmplDec pulses, then 3 more → Amplitude_o reaches 0 and stays 0; no AmplDirty set by the extra pulses. Then 255 AmplInc → 255.
- Drive FreqDec until tuning word is 0, then FreqInc with no PhaseWrap_i → TuningWord_o = 1 within 2 cycles (zero-word bypass).
- Both flags dirty in IDLE with LastSel = 0 → amplitude converted first, then frequency. ConvStart_o is exactly 1 cycle wide each time.
- HOLD_CYCLES = 100: one AmplInc, converter answers after 10 cycles → DisplaySel_o = 1; 100 cycles after ConvDone_i a frequency conversion starts; on its ConvDone_i, DisplaySel_o = 0. Asserting Reset mid-WAIT returns DisplaySel_o to 0 immediately.

Source files
------------

// File: rtl/dds_pkg.sv
// rtl/dds_pkg.sv - shared types and constants for the DDS parameter/display sequencer
//
// Purpose: display-FSM state encoding, display-source codes and default
//          datapath widths used by dds_controller and its bench.
// Ports:   none (package).

package dds_pkg;

  localparam int DEF_TW_WIDTH   = 16;
  localparam int DEF_AMPL_WIDTH = 8;

  // Display source codes; also used for the converter source and LastSel.
  localparam logic DISP_FREQ = 1'b0;
  localparam logic DISP_AMPL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } dispState_t;

endpackage

// File: rtl/dds_controller_satcnt.sv
// rtl/dds_controller_satcnt.sv - up/down counter that clamps at 0 and MAX_VAL
//
// Purpose: holds a value stepped by single-cycle Inc/Dec pulses, saturating
//          at 0 and MAX_VAL. Changed_o is a registered pulse that rises in the
//          same cycle the new value becomes visible.
// Ports:   Clock, Reset (async, active-high)
//          Inc_i, Dec_i  one-cycle step requests (both together = no step)
//          Value_o       current value
//          Changed_o     one-cycle pulse when Value_o just changed

module saturating_counter #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter logic [WIDTH-1:0] MAX_VAL   = '1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Inc_i,
  input  logic             Dec_i,
  output logic [WIDTH-1:0] Value_o,
  output logic             Changed_o
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      Value_o   <= RESET_VAL;
      Changed_o <= 1'b0;
    end else begin
      Changed_o <= 1'b0;
      if (Inc_i && !Dec_i && (Value_o != MAX_VAL)) begin
        Value_o   <= Value_o + ONE;
        Changed_o <= 1'b1;
      end else if (Dec_i && !Inc_i && (Value_o != '0)) begin
        Value_o   <= Value_o - ONE;
        Changed_o <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/dds_controller.sv
// rtl/dds_controller.sv - DDS tuning/amplitude registers and BCD display sequencer
//
// Purpose: keeps saturating tuning-word and amplitude registers driven by
//          encoder step pulses, commits the tuning word phase-coherently at
//          accumulator wrap, and time-shares one BCD converter between the
//          frequency and amplitude readouts with a timed amplitude hold.
// Ports:   Clock, Reset (async, active-high)
//          FreqInc_i/FreqDec_i    tuning-word step pulses
//          AmplInc_i/AmplDec_i    amplitude step pulses
//          PhaseWrap_i            accumulator overflow pulse
//          TuningWord_o           committed tuning word
//          Amplitude_o            amplitude scale
//          ConvStart_o/ConvValue_o/ConvDone_i  BCD converter handshake
//          DisplaySel_o           0 = frequency shown, 1 = amplitude shown

module dds_controller
  import dds_pkg::*;
#(
  parameter int TW_WIDTH    = DEF_TW_WIDTH,
  parameter int TW_RESET    = 1,
  parameter int TW_MAX      = 65535,
  parameter int AMPL_WIDTH  = DEF_AMPL_WIDTH,
  parameter int AMPL_RESET  = 255,
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  FreqInc_i,
  input  logic                  FreqDec_i,
  input  logic                  AmplInc_i,
  input  logic                  AmplDec_i,
  input  logic                  PhaseWrap_i,
  output logic [TW_WIDTH-1:0]   TuningWord_o,
  output logic [AMPL_WIDTH-1:0] Amplitude_o,
  output logic                  ConvStart_o,
  output logic [TW_WIDTH-1:0]   ConvValue_o,
  input  logic                  ConvDone_i,
  output logic                  DisplaySel_o
);

  localparam int              HOLD_W    = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  logic [TW_WIDTH-1:0] twPending;
  logic                twChangedUnused;
  logic                amplChanged;
  logic                twCommit;
  logic                twCommitChange;

  logic                freqDirty;
  logic                amplDirty;
  logic                lastSel;
  logic                curSrc;

  logic                holdActive;
  logic [HOLD_W-1:0]   holdCount;
  logic                holdExpire;

  dispState_t          state;
  dispState_t          nextState;
  logic                pickValid;
  logic                pickSrc;
  logic                convDoneAccepted;

  saturating_counter #(
    .WIDTH    (TW_WIDTH),
    .RESET_VAL(TW_WIDTH'(TW_RESET)),
    .MAX_VAL  (TW_WIDTH'(TW_MAX))
  ) twCounter (
    .Clock    (Clock),
    .Reset    (Reset),
    .Inc_i    (FreqInc_i),
    .Dec_i    (FreqDec_i),
    .Value_o  (twPending),
    .Changed_o(twChangedUnused)
  );

  saturating_counter #(
    .WIDTH    (AMPL_WIDTH),
    .RESET_VAL(AMPL_WIDTH'(AMPL_RESET)),
    .MAX_VAL  ({AMPL_WIDTH{1'b1}})
  ) amplCounter (
    .Clock    (Clock),
    .Reset    (Reset),
    .Inc_i    (AmplInc_i),
    .Dec_i    (AmplDec_i),
    .Value_o  (Amplitude_o),
    .Changed_o(amplChanged)
  );

  // A zero tuning word never wraps, so it is committed every cycle instead.
  // twPending is read before this edge's step lands, so a step coinciding
  // with a wrap waits for the next wrap.
  assign twCommit       = PhaseWrap_i || (TuningWord_o == '0);
  assign twCommitChange = twCommit && (twPending != TuningWord_o);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      TuningWord_o <= TW_WIDTH'(TW_RESET);
    end else if (twCommit) begin
      TuningWord_o <= twPending;
    end
  end

  // Display FSM: next state and source selection.
  always_comb begin
    nextState        = state;
    pickValid        = 1'b0;
    pickSrc          = DISP_FREQ;
    convDoneAccepted = 1'b0;
    case (state)
      ST_IDLE: begin
        if (freqDirty || amplDirty) begin
          pickValid = 1'b1;
          if (freqDirty && amplDirty) begin
            pickSrc = ~lastSel;
          end else if (amplDirty) begin
            pickSrc = DISP_AMPL;
          end else begin
            pickSrc = DISP_FREQ;
          end
          nextState = ST_START;
        end
      end
      ST_START: nextState = ST_WAIT;
      ST_WAIT: begin
        if (ConvDone_i) begin
          convDoneAccepted = 1'b1;
          nextState        = ST_IDLE;
        end
      end
      default: nextState = ST_IDLE;
    endcase
  end

  assign ConvStart_o = (state == ST_START);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state        <= ST_IDLE;
      ConvValue_o  <= '0;
      curSrc       <= DISP_FREQ;
      lastSel      <= DISP_AMPL;
      DisplaySel_o <= DISP_FREQ;
    end else begin
      state <= nextState;
      if (pickValid) begin
        curSrc      <= pickSrc;
        ConvValue_o <= (pickSrc == DISP_AMPL) ? TW_WIDTH'(Amplitude_o) : TuningWord_o;
      end
      if (convDoneAccepted) begin
        DisplaySel_o <= curSrc;
        lastSel      <= curSrc;
      end
    end
  end

  // Set wins over clear: a change landing in the capture cycle must still
  // produce a fresh conversion afterwards.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      freqDirty <= 1'b1;
      amplDirty <= 1'b0;
    end else begin
      if (twCommitChange || holdExpire) begin
        freqDirty <= 1'b1;
      end else if (pickValid && (pickSrc == DISP_FREQ)) begin
        freqDirty <= 1'b0;
      end
      if (amplChanged) begin
        amplDirty <= 1'b1;
      end else if (pickValid && (pickSrc == DISP_AMPL)) begin
        amplDirty <= 1'b0;
      end
    end
  end

  // Amplitude-display hold: expiry forces a frequency readout.
  assign holdExpire = holdActive && (holdCount == '0);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      holdActive <= 1'b0;
      holdCount  <= '0;
    end else if (convDoneAccepted) begin
      if (curSrc == DISP_AMPL) begin
        holdActive <= 1'b1;
        holdCount  <= HOLD_LOAD;
      end else begin
        holdActive <= 1'b0;
        holdCount  <= '0;
      end
    end else if (holdExpire) begin
      holdActive <= 1'b0;
    end else if (holdActive) begin
      holdCount <= holdCount - HOLD_ONE;
    end
  end

endmodule

// File: tb/tb_dds_controller.sv
// tb/tb_dds_controller.sv - directed scoreboard bench for dds_controller

module tb_dds_controller;
  import dds_pkg::*;

  typedef struct {
    logic        src;
    logic [15:0] value;
  } sbEntry_t;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        FreqInc_i = 1'b0;
  logic        FreqDec_i = 1'b0;
  logic        AmplInc_i = 1'b0;
  logic        AmplDec_i = 1'b0;
  logic        PhaseWrap_i = 1'b0;
  logic        ConvDone_i = 1'b0;
  logic [15:0] TuningWord_o;
  logic [7:0]  Amplitude_o;
  logic        ConvStart_o;
  logic [15:0] ConvValue_o;
  logic        DisplaySel_o;

  sbEntry_t    sb[$];
  sbEntry_t    e;
  int          nCompared = 0;
  int          nMismatch = 0;
  logic        inflight = 1'b0;
  logic        curSrc = 1'b0;
  logic        prevStart = 1'b0;

  dds_controller #(.HOLD_CYCLES(100)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .FreqInc_i   (FreqInc_i),
    .FreqDec_i   (FreqDec_i),
    .AmplInc_i   (AmplInc_i),
    .AmplDec_i   (AmplDec_i),
    .PhaseWrap_i (PhaseWrap_i),
    .TuningWord_o(TuningWord_o),
    .Amplitude_o (Amplitude_o),
    .ConvStart_o (ConvStart_o),
    .ConvValue_o (ConvValue_o),
    .ConvDone_i  (ConvDone_i),
    .DisplaySel_o(DisplaySel_o)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nCompared++;
    assert (obs === expv) else begin
      nMismatch++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // One clock; outputs sampled 1ns after the edge. Every converter start is
  // matched against the head of the scoreboard.
  task automatic tick();
    @(posedge Clock);
    #1;
    if (ConvStart_o === 1'b1) begin
      check("start_width", prevStart, 1'b0);
      check("sb_has_entry", (sb.size() > 0), 1'b1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("conv_value", ConvValue_o, e.value);
        curSrc = e.src;
      end
      inflight = 1'b1;
    end
    prevStart = ConvStart_o;
  endtask

  task automatic waitStart(input int limit, input string tag, output int n);
    n = 0;
    while (!inflight && n < limit) begin
      tick();
      n++;
    end
    check(tag, inflight, 1'b1);
  endtask

  task automatic answer(input int delay, input string tag);
    check({tag, "_inflight"}, inflight, 1'b1);
    repeat (delay) tick();
    ConvDone_i = 1'b1;
    tick();
    ConvDone_i = 1'b0;
    inflight = 1'b0;
    check({tag, "_disp"}, DisplaySel_o, curSrc);
  endtask

  task automatic pulseAmpl(input logic inc, input logic [7:0] expAmpl, input string tag);
    AmplInc_i = inc;
    AmplDec_i = ~inc;
    tick();
    AmplInc_i = 1'b0;
    AmplDec_i = 1'b0;
    check(tag, Amplitude_o, expAmpl);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] modelTw, modelPend;
    logic [7:0]  modelAmpl;
    logic        inc, wrap;
    int          changes, n, k;

    // Reset state and the initial frequency readout.
    repeat (3) tick();
    check("rst_tw", TuningWord_o, 16'd1);
    check("rst_ampl", Amplitude_o, 8'd255);
    check("rst_start", ConvStart_o, 1'b0);
    check("rst_value", ConvValue_o, 16'd0);
    check("rst_disp", DisplaySel_o, 1'b0);
    sb.push_back('{DISP_FREQ, 16'd1});
    Reset = 1'b0;
    waitStart(10, "init_start", n);
    answer(3, "init");

    // 15 FreqInc pulses, wrap every 20 cycles, one inc coincident with a wrap (t=59).
    modelTw = 16'd1;
    modelPend = 16'd1;
    changes = 0;
    for (int t = 0; t < 126; t++) begin
      inc  = (t >= 3) && (t <= 101) && (((t - 3) % 7) == 0);
      wrap = ((t % 20) == 19);
      FreqInc_i = inc;
      PhaseWrap_i = wrap;
      if ((wrap || modelTw == 16'd0) && modelPend != modelTw) begin
        modelTw = modelPend;
        changes++;
        if (changes == 1) sb.push_back('{DISP_FREQ, modelTw});
      end
      if (inc && modelPend != 16'hFFFF) modelPend++;
      tick();
      FreqInc_i = 1'b0;
      PhaseWrap_i = 1'b0;
      check("tw_step", TuningWord_o, modelTw);
    end
    check("tw_final", TuningWord_o, 16'd16);
    if (changes > 1) sb.push_back('{DISP_FREQ, modelTw});
    answer(2, "freq_first");
    waitStart(10, "freq_last_start", n);
    answer(2, "freq_last");

    // Amplitude down to 0 while the converter is busy, then saturation.
    modelAmpl = 8'd254;
    sb.push_back('{DISP_AMPL, 16'd254});
    pulseAmpl(1'b0, modelAmpl, "ampl_dec");
    waitStart(10, "ampl254_start", n);
    for (int i = 0; i < 254; i++) begin
      modelAmpl--;
      pulseAmpl(1'b0, modelAmpl, "ampl_dec");
    end
    sb.push_back('{DISP_AMPL, 16'd0});
    answer(2, "ampl254");
    waitStart(10, "ampl0_start", n);
    answer(2, "ampl0");
    for (int i = 0; i < 3; i++) pulseAmpl(1'b0, 8'd0, "ampl_sat_lo");
    repeat (20) tick();
    check("no_dirty_sat_lo", inflight, 1'b0);
    sb.push_back('{DISP_FREQ, 16'd16});
    waitStart(150, "hold_rev1_start", n);
    answer(2, "hold_rev1");

    // Amplitude back up to 255.
    modelAmpl = 8'd1;
    sb.push_back('{DISP_AMPL, 16'd1});
    pulseAmpl(1'b1, modelAmpl, "ampl_inc");
    waitStart(10, "ampl1_start", n);
    for (int i = 0; i < 254; i++) begin
      modelAmpl++;
      pulseAmpl(1'b1, modelAmpl, "ampl_inc");
    end
    sb.push_back('{DISP_AMPL, 16'd255});
    answer(2, "ampl1");
    waitStart(10, "ampl255_start", n);
    answer(2, "ampl255");
    pulseAmpl(1'b1, 8'd255, "ampl_sat_hi");
    repeat (20) tick();
    check("no_dirty_sat_hi", inflight, 1'b0);
    sb.push_back('{DISP_FREQ, 16'd16});
    waitStart(150, "hold_rev2_start", n);
    answer(2, "hold_rev2");

    // Tuning word down to 0 (17 decs, one saturated), then zero-word bypass.
    for (int i = 0; i < 17; i++) begin
      FreqDec_i = 1'b1;
      tick();
      FreqDec_i = 1'b0;
      tick();
    end
    check("tw_no_wrap_hold", TuningWord_o, 16'd16);
    sb.push_back('{DISP_FREQ, 16'd0});
    PhaseWrap_i = 1'b1;
    tick();
    PhaseWrap_i = 1'b0;
    check("tw_zero", TuningWord_o, 16'd0);
    waitStart(10, "tw0_start", n);
    answer(2, "tw0");
    sb.push_back('{DISP_FREQ, 16'd1});
    FreqInc_i = 1'b1;
    tick();
    FreqInc_i = 1'b0;
    tick();
    check("tw_zero_bypass", TuningWord_o, 16'd1);
    waitStart(10, "tw1_start", n);
    answer(2, "tw1");

    // Inc and Dec together: nothing changes, nothing converts.
    FreqInc_i = 1'b1; FreqDec_i = 1'b1; AmplInc_i = 1'b1; AmplDec_i = 1'b1;
    tick();
    FreqInc_i = 1'b0; FreqDec_i = 1'b0; AmplInc_i = 1'b0; AmplDec_i = 1'b0;
    PhaseWrap_i = 1'b1;
    tick();
    PhaseWrap_i = 1'b0;
    repeat (10) tick();
    check("incdec_tw", TuningWord_o, 16'd1);
    check("incdec_ampl", Amplitude_o, 8'd255);
    check("incdec_no_conv", inflight, 1'b0);

    // Both dirty with LastSel = freq: amplitude first, then frequency.
    sb.push_back('{DISP_AMPL, 16'd254});
    sb.push_back('{DISP_FREQ, 16'd2});
    FreqInc_i = 1'b1;
    AmplDec_i = 1'b1;
    tick();
    FreqInc_i = 1'b0;
    AmplDec_i = 1'b0;
    PhaseWrap_i = 1'b1;
    tick();
    PhaseWrap_i = 1'b0;
    waitStart(10, "both_a_start", n);
    answer(2, "both_a");
    waitStart(10, "both_f_start", n);
    answer(2, "both_f");

    // Start latency and hold timer.
    sb.push_back('{DISP_AMPL, 16'd255});
    AmplInc_i = 1'b1;
    tick();
    AmplInc_i = 1'b0;
    waitStart(10, "lat_start", n);
    check("ampl_start_latency", n + 1, 3);
    answer(10, "hold_ampl");
    sb.push_back('{DISP_FREQ, 16'd2});
    k = 0;
    while (!inflight && k < 200) begin
      tick();
      k++;
      if (k == 99) check("hold_disp", DisplaySel_o, 1'b1);
    end
    check("hold_revert_window", (k >= 100 && k <= 104), 1'b1);
    answer(3, "hold_freq");

    // Reset while waiting on the converter.
    sb.push_back('{DISP_AMPL, 16'd254});
    AmplDec_i = 1'b1;
    tick();
    AmplDec_i = 1'b0;
    waitStart(10, "pre_rst_start", n);
    answer(2, "pre_rst");
    sb.push_back('{DISP_AMPL, 16'd255});
    AmplInc_i = 1'b1;
    tick();
    AmplInc_i = 1'b0;
    waitStart(10, "mid_rst_start", n);
    repeat (3) tick();
    Reset = 1'b1;
    #1;
    check("midrst_disp", DisplaySel_o, 1'b0);
    check("midrst_tw", TuningWord_o, 16'd1);
    check("midrst_start", ConvStart_o, 1'b0);
    tick();
    inflight = 1'b0;
    prevStart = 1'b0;
    sb.push_back('{DISP_FREQ, 16'd1});
    Reset = 1'b0;
    ConvDone_i = 1'b1;
    tick();
    ConvDone_i = 1'b0;
    check("stale_done_disp", DisplaySel_o, 1'b0);
    waitStart(10, "post_rst_start", n);
    answer(2, "post_rst");
    repeat (120) tick();
    check("post_rst_quiet", inflight, 1'b0);
    check("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
